// File: rtl/iir_axi4lite_mc_if.sv
// AXI4-lite bus bundle for the multi-channel IIR engine.
// slave: the engine side; master: the driving side (CPU or testbench).
interface iir_axi4lite_mc_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic [AW-1:0]   i_axi_awaddr;
    logic            i_axi_awvalid;
    logic            o_axi_awready;
    logic [DW-1:0]   i_axi_wdata;
    logic [DW/8-1:0] i_axi_wstrb;
    logic            i_axi_wvalid;
    logic            o_axi_wready;
    logic [1:0]      o_axi_bresp;
    logic            o_axi_bvalid;
    logic            i_axi_bready;
    logic [AW-1:0]   i_axi_araddr;
    logic            i_axi_arvalid;
    logic            o_axi_arready;
    logic [DW-1:0]   o_axi_rdata;
    logic [1:0]      o_axi_rresp;
    logic            o_axi_rvalid;
    logic            i_axi_rready;

    modport slave (
        input  i_axi_awaddr, i_axi_awvalid,
        input  i_axi_wdata, i_axi_wstrb, i_axi_wvalid,
        input  i_axi_bready,
        input  i_axi_araddr, i_axi_arvalid,
        input  i_axi_rready,
        output o_axi_awready, o_axi_wready,
        output o_axi_bresp, o_axi_bvalid,
        output o_axi_arready,
        output o_axi_rdata, o_axi_rresp, o_axi_rvalid
    );

    modport master (
        output i_axi_awaddr, i_axi_awvalid,
        output i_axi_wdata, i_axi_wstrb, i_axi_wvalid,
        output i_axi_bready,
        output i_axi_araddr, i_axi_arvalid,
        output i_axi_rready,
        input  o_axi_awready, o_axi_wready,
        input  o_axi_bresp, o_axi_bvalid,
        input  o_axi_arready,
        input  o_axi_rdata, o_axi_rresp, o_axi_rvalid
    );
endinterface

// File: rtl/iir_axi4lite_mc.sv
// Multi-channel programmable first-order IIR engine behind an AXI4-lite slave.
// Ports: clk_i, rst_i (sync, active-high), bus (AXI4-lite slave), o_irq.
module iir_axi4lite_mc #(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int SW     = 16,
    parameter int FRAC   = 8,
    parameter int DEPTH  = 32,
    parameter int NUM_CH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    iir_axi4lite_mc_if.slave bus,
    output logic             o_irq
);
    localparam int N   = NUM_CH * DEPTH;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int NW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW  = 2 * SW;
    localparam int ACW = 2 * SW + 2;

    localparam logic [AW-1:0] A_CTRL   = AW'(32'h000);
    localparam logic [AW-1:0] A_STAT   = AW'(32'h004);
    localparam logic [AW-1:0] A_B0     = AW'(32'h008);
    localparam logic [AW-1:0] A_B1     = AW'(32'h00C);
    localparam logic [AW-1:0] A_A1     = AW'(32'h010);
    localparam logic [AW-1:0] IN_BASE  = AW'(32'h400);
    localparam logic [AW-1:0] OUT_BASE = AW'(32'h800);
    localparam logic [AW-1:0] SPAN     = AW'(4 * N);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [NW-1:0] LAST_N   = NW'(DEPTH - 1);
    localparam logic [SW-1:0] B0_RST   = SW'(1 << FRAC);

    localparam logic signed [ACW-1:0] Y_MAX =
        {{(SW+3){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [ACW-1:0] Y_MIN =
        {{(SW+3){1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic [2:0] {
        RG_CTRL, RG_STAT, RG_B0, RG_B1,
        RG_A1, RG_IN, RG_OUT, RG_NONE
    } reg_e;

    typedef enum logic [1:0] {
        S_IDLE, S_RD, S_MAC, S_FIN
    } state_e;

    function automatic reg_e decode(input logic [AW-1:0] a);
        logic [AW-1:0] w;
        w = {a[AW-1:2], 2'b00};
        decode = RG_NONE;
        if (w == A_CTRL)
            decode = RG_CTRL;
        else if (w == A_STAT)
            decode = RG_STAT;
        else if (w == A_B0)
            decode = RG_B0;
        else if (w == A_B1)
            decode = RG_B1;
        else if (w == A_A1)
            decode = RG_A1;
        else if (w >= IN_BASE && w < IN_BASE + SPAN)
            decode = RG_IN;
        else if (w >= OUT_BASE && w < OUT_BASE + SPAN)
            decode = RG_OUT;
    endfunction

    function automatic logic [IW-1:0] buf_idx(
        input logic [AW-1:0] a,
        input logic [AW-1:0] base
    );
        logic [AW-1:0] off;
        off = a - base;
        buf_idx = off[IW+1:2];
    endfunction

    function automatic logic [DW-1:0] sext(input logic [SW-1:0] v);
        sext = {{(DW-SW){v[SW-1]}}, v};
    endfunction

    logic [SW-1:0] in_mem  [N];
    logic [SW-1:0] out_mem [N];

    state_e               state;
    logic                 busy;
    logic                 done;
    logic                 irq_en;
    logic signed [SW-1:0] b0, b1, a1;
    logic signed [SW-1:0] x_q, x_prev, y_prev;
    logic [IW-1:0]        idx;
    logic [NW-1:0]        n_cnt;

    logic          aw_rdy;
    logic          bvalid;
    logic [1:0]    bresp;
    logic          ar_rdy;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    // ---------------- write decode ----------------
    logic          wr_fire;
    reg_e          wr_reg;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wdat;
    logic          wr_err;
    logic          in_we;
    logic          start_go;

    assign wr_fire = aw_rdy & bus.i_axi_awvalid & bus.i_axi_wvalid;
    assign wr_reg  = decode(bus.i_axi_awaddr);
    assign wr_idx  = buf_idx(bus.i_axi_awaddr, IN_BASE);
    assign wdat    = bus.i_axi_wdata;

    // Strobes are ignored (partial strobe acts as full) and only the
    // low SW data bits are architecturally meaningful.
    logic unused_wr;
    assign unused_wr = ^{bus.i_axi_wstrb, wdat[DW-1:SW]};

    always_comb begin
        wr_err   = 1'b0;
        in_we    = 1'b0;
        start_go = 1'b0;
        unique case (wr_reg)
            RG_CTRL: start_go = wr_fire & wdat[0] & ~busy;
            RG_STAT: wr_err = 1'b0;
            RG_B0, RG_B1, RG_A1: wr_err = busy;
            RG_IN: begin
                wr_err = busy;
                in_we  = wr_fire & ~busy;
            end
            default: wr_err = 1'b1;
        endcase
    end

    // ---------------- MAC datapath ----------------
    logic signed [PW-1:0]  p_b0, p_b1, p_a1;
    logic signed [ACW-1:0] acc, acc_sh;
    logic signed [SW-1:0]  y_sat;

    always_comb begin
        p_b0   = PW'(b0) * PW'(x_q);
        p_b1   = PW'(b1) * PW'(x_prev);
        p_a1   = PW'(a1) * PW'(y_prev);
        acc    = ACW'(p_b0) + ACW'(p_b1) + ACW'(p_a1);
        acc_sh = acc >>> FRAC;
        if (acc_sh > Y_MAX)
            y_sat = Y_MAX[SW-1:0];
        else if (acc_sh < Y_MIN)
            y_sat = Y_MIN[SW-1:0];
        else
            y_sat = acc_sh[SW-1:0];
    end

    // ------------- write channel, regs, FSM -------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_rdy <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= 2'b00;
            irq_en <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            b0     <= B0_RST;
            b1     <= '0;
            a1     <= '0;
            state  <= S_IDLE;
            idx    <= '0;
            n_cnt  <= '0;
            x_q    <= '0;
            x_prev <= '0;
            y_prev <= '0;
            o_irq  <= 1'b0;
        end else begin
            aw_rdy <= ~aw_rdy & bus.i_axi_awvalid
                    & bus.i_axi_wvalid & ~bvalid;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? 2'b10 : 2'b00;
                unique case (wr_reg)
                    RG_CTRL: irq_en <= wdat[1];
                    RG_STAT: if (wdat[0]) done <= 1'b0;
                    RG_B0:   if (!busy) b0 <= wdat[SW-1:0];
                    RG_B1:   if (!busy) b1 <= wdat[SW-1:0];
                    RG_A1:   if (!busy) a1 <= wdat[SW-1:0];
                    default: ;
                endcase
            end else if (bvalid && bus.i_axi_bready) begin
                bvalid <= 1'b0;
            end

            o_irq <= done & irq_en;

            // FSM updates come last so FIN's DONE set wins
            // over a same-cycle DONE clear.
            unique case (state)
                S_IDLE: begin
                    if (start_go) begin
                        state  <= S_RD;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        idx    <= '0;
                        n_cnt  <= '0;
                        x_prev <= '0;
                        y_prev <= '0;
                    end
                end
                S_RD: begin
                    x_q   <= in_mem[idx];
                    state <= S_MAC;
                end
                S_MAC: begin
                    idx <= idx + IW'(1);
                    // Channel boundary: next channel starts from rest.
                    if (n_cnt == LAST_N) begin
                        n_cnt  <= '0;
                        x_prev <= '0;
                        y_prev <= '0;
                    end else begin
                        n_cnt  <= n_cnt + NW'(1);
                        x_prev <= x_q;
                        y_prev <= y_sat;
                    end
                    state <= (idx == LAST_IDX) ? S_FIN : S_RD;
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample buffers are never cleared by reset.
    always_ff @(posedge clk_i) begin
        if (in_we && !rst_i)
            in_mem[wr_idx] <= wdat[SW-1:0];
        if (state == S_MAC)
            out_mem[idx] <= y_sat;
    end

    // ---------------- read channel ----------------
    logic          rd_fire;
    reg_e          rd_reg;
    logic [IW-1:0] rd_in_idx;
    logic [IW-1:0] rd_out_idx;

    assign rd_fire    = ar_rdy & bus.i_axi_arvalid;
    assign rd_reg     = decode(bus.i_axi_araddr);
    assign rd_in_idx  = buf_idx(bus.i_axi_araddr, IN_BASE);
    assign rd_out_idx = buf_idx(bus.i_axi_araddr, OUT_BASE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ar_rdy <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else begin
            ar_rdy <= ~ar_rdy & bus.i_axi_arvalid & ~rvalid;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                unique case (rd_reg)
                    RG_CTRL: rdata <= DW'({irq_en, 1'b0});
                    RG_STAT: rdata <= DW'({busy, done});
                    RG_B0:   rdata <= sext(b0);
                    RG_B1:   rdata <= sext(b1);
                    RG_A1:   rdata <= sext(a1);
                    RG_IN:   rdata <= sext(in_mem[rd_in_idx]);
                    RG_OUT:  rdata <= sext(out_mem[rd_out_idx]);
                    default: begin
                        rdata <= '0;
                        rresp <= 2'b10;
                    end
                endcase
            end else if (rvalid && bus.i_axi_rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign bus.o_axi_awready = aw_rdy;
    assign bus.o_axi_wready  = aw_rdy;
    assign bus.o_axi_bvalid  = bvalid;
    assign bus.o_axi_bresp   = bresp;
    assign bus.o_axi_arready = ar_rdy;
    assign bus.o_axi_rvalid  = rvalid;
    assign bus.o_axi_rdata   = rdata;
    assign bus.o_axi_rresp   = rresp;
endmodule

// File: tb/tb_iir_axi4lite_mc.sv
// Self-checking bench for iir_axi4lite_mc: register vectors,
// directed filter scenarios and randomized runs against a reference model.
module tb_iir_axi4lite_mc;
    localparam int DEPTH = 32;
    localparam int NCH   = 2;
    localparam int N     = NCH * DEPTH;
    localparam int LAT   = 2 * N + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    iir_axi4lite_mc_if #(.AW(12), .DW(32)) bus ();

    iir_axi4lite_mc #(
        .AW(12), .DW(32), .SW(16), .FRAC(8),
        .DEPTH(DEPTH), .NUM_CH(NCH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave),
        .o_irq (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int hs_cyc = 0;

    int in_v [N];
    int exp_v [N];
    int cb0 = 256;
    int cb1 = 0;
    int ca1 = 0;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             output logic [1:0] resp);
        int t = 0;
        @(negedge clk);
        bus.i_axi_awaddr  = a;
        bus.i_axi_wdata   = d;
        bus.i_axi_wstrb   = 4'hF;
        bus.i_axi_awvalid = 1'b1;
        bus.i_axi_wvalid  = 1'b1;
        while (!bus.o_axi_awready && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (!bus.o_axi_awready) begin
            check("aw_timeout", 32'd0, 32'd1);
            bus.i_axi_awvalid = 1'b0;
            bus.i_axi_wvalid  = 1'b0;
            resp = 2'bxx;
            return;
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        bus.i_axi_awvalid = 1'b0;
        bus.i_axi_wvalid  = 1'b0;
        if (!bus.o_axi_bvalid)
            check("bvalid_late", 32'd0, 32'd1);
        resp = bus.o_axi_bresp;
        @(posedge clk);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int t = 0;
        @(negedge clk);
        bus.i_axi_araddr  = a;
        bus.i_axi_arvalid = 1'b1;
        while (!bus.o_axi_arready && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (!bus.o_axi_arready) begin
            check("ar_timeout", 32'd0, 32'd1);
            bus.i_axi_arvalid = 1'b0;
            d = 'x;
            resp = 2'bxx;
            return;
        end
        @(posedge clk);
        #1;
        bus.i_axi_arvalid = 1'b0;
        if (!bus.o_axi_rvalid)
            check("rvalid_late", 32'd0, 32'd1);
        d = bus.o_axi_rdata;
        resp = bus.o_axi_rresp;
        @(posedge clk);
    endtask

    // Reference: per channel, direct-form recursion with floor shift
    // and saturation, starting from zero history.
    function automatic void model();
        for (int ch = 0; ch < NCH; ch++) begin
            int xp = 0;
            int yp = 0;
            for (int n = 0; n < DEPTH; n++) begin
                longint acc;
                int x;
                int y;
                x = in_v[ch*DEPTH + n];
                acc = longint'(cb0) * x + longint'(cb1) * xp
                    + longint'(ca1) * yp;
                y = int'(acc >>> 8);
                if (y > 32767) y = 32767;
                if (y < -32768) y = -32768;
                exp_v[ch*DEPTH + n] = y;
                xp = x;
                yp = y;
            end
        end
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    task automatic set_coefs(input int x, input int y, input int z);
        logic [1:0] r;
        cb0 = x;
        cb1 = y;
        ca1 = z;
        axi_write(12'h008, 32'(x), r);
        axi_write(12'h00C, 32'(y), r);
        axi_write(12'h010, 32'(z), r);
    endtask

    task automatic load_in();
        logic [1:0] r;
        for (int i = 0; i < N; i++)
            axi_write(12'h400 + 12'(4*i), 32'(in_v[i]), r);
    endtask

    task automatic start_irq(output int hs);
        logic [1:0] r;
        axi_write(12'h000, 32'h3, r);
        hs = hs_cyc;
    endtask

    task automatic wait_irq(input string name, input int hs);
        int t = 0;
        while (!irq && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!irq)
            check({name, "_irq_timeout"}, 32'd0, 32'd1);
        else
            check({name, "_done_lat"}, 32'(cyc - hs), 32'(LAT));
    endtask

    task automatic finish_run(input string name);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(12'h004, d, r);
        check({name, "_status"}, d, 32'h1);
        model();
        for (int i = 0; i < N; i++) begin
            axi_read(12'h800 + 12'(4*i), d, r);
            check({name, "_out"}, d, 32'(exp_v[i]));
        end
        axi_write(12'h004, 32'h1, r);
        @(negedge clk);
        check({name, "_irq_clr"}, 32'(irq), 32'h0);
    endtask

    task automatic run(input string name);
        int hs;
        load_in();
        start_irq(hs);
        wait_irq(name, hs);
        finish_run(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int hs;

        bus.i_axi_awaddr  = '0;
        bus.i_axi_awvalid = 1'b0;
        bus.i_axi_wdata   = '0;
        bus.i_axi_wstrb   = '0;
        bus.i_axi_wvalid  = 1'b0;
        bus.i_axi_bready  = 1'b1;
        bus.i_axi_araddr  = '0;
        bus.i_axi_arvalid = 1'b0;
        bus.i_axi_rready  = 1'b1;

        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_bvalid", 32'(bus.o_axi_bvalid), 32'h0);
        check("rst_rvalid", 32'(bus.o_axi_rvalid), 32'h0);

        vt.push_back('{0, 12'h000, 32'h0, 2'b00, "ctrl_rst"});
        vt.push_back('{0, 12'h004, 32'h0, 2'b00, "status_rst"});
        vt.push_back('{0, 12'h008, 32'h100, 2'b00, "b0_rst"});
        vt.push_back('{0, 12'h00C, 32'h0, 2'b00, "b1_rst"});
        vt.push_back('{0, 12'h010, 32'h0, 2'b00, "a1_rst"});
        vt.push_back('{0, 12'h300, 32'h0, 2'b10, "rd_unmapped"});
        vt.push_back('{1, 12'h800, 32'h1, 2'b10, "wr_out"});
        vt.push_back('{1, 12'h0FC, 32'h1, 2'b10, "wr_unmapped"});
        vt.push_back('{1, 12'h500, 32'h1, 2'b10, "wr_in_oob"});
        vt.push_back('{0, 12'h500, 32'h0, 2'b10, "rd_in_oob"});
        vt.push_back('{1, 12'h00C, 32'hABCDFFF0, 2'b00, "wr_b1"});
        vt.push_back('{0, 12'h00C, 32'hFFFFFFF0, 2'b00, "b1_sext"});
        vt.push_back('{1, 12'h00C, 32'h0, 2'b00, "wr_b1_zero"});
        vt.push_back('{0, 12'h00C, 32'h0, 2'b00, "b1_zero"});
        vt.push_back('{1, 12'h4FC, 32'h12348001, 2'b00, "wr_in_last"});
        vt.push_back('{0, 12'h4FC, 32'hFFFF8001, 2'b00, "in_sext"});
        vt.push_back('{1, 12'h000, 32'h2, 2'b00, "wr_irq_en"});
        vt.push_back('{0, 12'h000, 32'h2, 2'b00, "irq_en_rd"});
        vt.push_back('{1, 12'h000, 32'h0, 2'b00, "wr_ctrl_zero"});
        vt.push_back('{0, 12'h000, 32'h0, 2'b00, "ctrl_zero"});

        foreach (vt[i]) begin
            if (vt[i].wr) begin
                axi_write(vt[i].addr, vt[i].data, r);
                check({vt[i].name, "_bresp"}, 32'(r), 32'(vt[i].resp));
            end else begin
                axi_read(vt[i].addr, d, r);
                check({vt[i].name, "_rdata"}, d, vt[i].data);
                check({vt[i].name, "_rresp"}, 32'(r), 32'(vt[i].resp));
            end
        end

        // Identity with default coefficients.
        for (int i = 0; i < N; i++)
            in_v[i] = (i < DEPTH) ? 4 * i : rnd16();
        run("identity");
        for (int i = 0; i < DEPTH; i++) begin
            axi_read(12'h800 + 12'(4*i), d, r);
            check("identity_ch0", d, 32'(4 * i));
        end

        // Two-tap average.
        set_coefs(32'h080, 32'h080, 0);
        for (int i = 0; i < N; i++)
            in_v[i] = rnd16();
        in_v[0] = 0;
        in_v[1] = 4;
        in_v[2] = 8;
        in_v[3] = 12;
        run("fir");
        axi_read(12'h800, d, r);
        check("fir_y0", d, 32'd0);
        axi_read(12'h804, d, r);
        check("fir_y1", d, 32'd2);
        axi_read(12'h808, d, r);
        check("fir_y2", d, 32'd6);
        axi_read(12'h80C, d, r);
        check("fir_y3", d, 32'd10);

        // Recursion on ch1 decays by half each step.
        set_coefs(32'h100, 0, 32'h080);
        for (int i = 0; i < N; i++)
            in_v[i] = (i < DEPTH) ? rnd16() : 0;
        in_v[DEPTH] = 256;
        run("recur");
        for (int i = 0; i < 4; i++) begin
            axi_read(12'h800 + 12'(4*(DEPTH+i)), d, r);
            check("recur_ch1", d, 32'(256 >> i));
        end

        // Saturation at both rails.
        set_coefs(32'h7FFF, 0, 0);
        for (int i = 0; i < N; i++)
            in_v[i] = rnd16();
        in_v[0] = 16384;
        in_v[1] = -16384;
        run("sat");
        axi_read(12'h800, d, r);
        check("sat_pos", d, 32'h00007FFF);
        axi_read(12'h804, d, r);
        check("sat_neg", d, 32'hFFFF8000);

        // Randomized runs: two moderate, one full-range coefficient set.
        for (int k = 0; k < 3; k++) begin
            if (k < 2)
                set_coefs(int'($urandom_range(1023)) - 512,
                          int'($urandom_range(1023)) - 512,
                          int'($urandom_range(511)) - 256);
            else
                set_coefs(rnd16(), rnd16(), rnd16());
            for (int i = 0; i < N; i++)
                in_v[i] = rnd16();
            run("random");
        end

        // Accesses while BUSY.
        set_coefs(32'h100, 32'h040, -32);
        for (int i = 0; i < N; i++)
            in_v[i] = rnd16();
        load_in();
        start_irq(hs);
        axi_write(12'h008, 32'h1234, r);
        check("busy_b0_bresp", 32'(r), 32'h2);
        axi_write(12'h404, 32'h5555, r);
        check("busy_in_bresp", 32'(r), 32'h2);
        axi_write(12'h000, 32'h3, r);
        check("busy_start_bresp", 32'(r), 32'h0);
        axi_read(12'h004, d, r);
        check("busy_status", d, 32'h2);
        axi_read(12'h800, d, r);
        check("busy_out_rresp", 32'(r), 32'h0);
        wait_irq("busy", hs);
        axi_read(12'h008, d, r);
        check("busy_b0_kept", d, 32'h100);
        axi_read(12'h404, d, r);
        check("busy_in_kept", d, 32'(in_v[1]));
        finish_run("busy");

        // Reset in the middle of a run.
        set_coefs(32'h7FFF, 0, 0);
        start_irq(hs);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cb0 = 256;
        cb1 = 0;
        ca1 = 0;
        check("mid_rst_irq", 32'(irq), 32'h0);
        axi_read(12'h004, d, r);
        check("mid_rst_status", d, 32'h0);
        axi_read(12'h008, d, r);
        check("mid_rst_b0", d, 32'h100);
        axi_read(12'h000, d, r);
        check("mid_rst_ctrl", d, 32'h0);
        for (int i = 0; i < N; i++)
            in_v[i] = rnd16();
        run("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
